spi_master_sevenseg: RTL and testbench

SPI mode-0 transmitter that serialises 6-bit display frames (2-bit command + 4-bit hex nibble, MSB first) onto sclk/ss/mosi. It is the initiator for the seven-segment SPI display slave. Frames enter through a valid/ready handshake into a one-entry holding register, so one frame can queue while another shifts. It sits between a host-side controller (counter, test pattern engine, or pin-driven inputs) and the display slave's SPI pins.

---
 rtl/spi_master_sevenseg.sv | 186 ++++++++++++++++++
 tb/tb_spi_master_sevenseg.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_sevenseg.sv
// SPI mode-0 initiator for the seven-segment display slave: serialises
// 6-bit {cmd, nibble} frames MSB first, with a one-entry holding register.
module spi_master_sevenseg #(
   parameter int CLK_DIV    = 4,
   parameter int TAIL_CLKS  = 0,
   parameter int GAP_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic [1:0] in_cmd_i,
   input  logic [3:0] in_data_i,
   output logic       sclk_o,
   output logic       ss_o,
   output logic       mosi_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int NBITS   = 6 + TAIL_CLKS;
   localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int BW      = $clog2(NBITS + 1);

   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_GAP   = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] div_cnt_q, div_cnt_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [5:0]    shift_q, shift_d;
   logic [5:0]    hold_q, hold_d;
   logic          hold_valid_q, hold_valid_d;
   logic          in_ready_q, in_ready_d;
   logic          sclk_q, sclk_d;
   logic          ss_q, ss_d;
   logic          mosi_q, mosi_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          accept_s;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         div_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= 6'd0;
         hold_q       <= 6'd0;
         hold_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         sclk_q       <= 1'b0;
         ss_q         <= 1'b1;
         mosi_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         in_ready_q   <= in_ready_d;
         sclk_q       <= sclk_d;
         ss_q         <= ss_d;
         mosi_q       <= mosi_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Next-state logic: frame sequencing and holding-register handshake
   always_comb begin
      state_d      = state_q;
      div_cnt_d    = div_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      sclk_d       = sclk_q;
      ss_d         = ss_q;
      mosi_d       = mosi_q;
      done_d       = 1'b0;
      accept_s     = in_valid_i && in_ready_q;

      case (state_q)
         S_IDLE: begin
            if (hold_valid_q) begin
               shift_d      = hold_q;
               hold_valid_d = 1'b0;
               ss_d         = 1'b0;
               mosi_d       = hold_q[5];
               sclk_d       = 1'b0;
               div_cnt_d    = '0;
               bit_cnt_d    = '0;
               state_d      = S_SETUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               sclk_d    = 1'b1;
               state_d   = S_HIGH;
            end else begin
               div_cnt_d = div_cnt_q + CW'(1);
            end
         end
         S_HIGH: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               sclk_d    = 1'b0;
               // Final falling edge and ss release share one edge, so ss is
               // low for exactly two half-periods per transmitted clock.
               if (bit_cnt_q == BIT_LAST) begin
                  ss_d    = 1'b1;
                  mosi_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_GAP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
                  shift_d   = {shift_q[4:0], 1'b0};
                  mosi_d    = shift_q[4];
                  state_d   = S_LOW;
               end
            end else begin
               div_cnt_d = div_cnt_q + CW'(1);
            end
         end
         S_LOW: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               sclk_d    = 1'b1;
               state_d   = S_HIGH;
            end else begin
               div_cnt_d = div_cnt_q + CW'(1);
            end
         end
         S_GAP: begin
            if (div_cnt_q == GAP_LAST) begin
               div_cnt_d = '0;
               state_d   = S_IDLE;
            end else begin
               div_cnt_d = div_cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            sclk_d  = 1'b0;
            ss_d    = 1'b1;
            mosi_d  = 1'b0;
         end
      endcase

      // Accept only when the hold register is empty, so it never meets a load
      if (accept_s) begin
         hold_d       = {in_cmd_i, in_data_i};
         hold_valid_d = 1'b1;
      end else begin
         hold_d = hold_d;
      end

      in_ready_d = !hold_valid_d;
      busy_d     = hold_valid_d || (state_d != S_IDLE);
   end

   assign in_ready_o = in_ready_q;
   assign sclk_o     = sclk_q;
   assign ss_o       = ss_q;
   assign mosi_o     = mosi_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule

// File: tb/tb_spi_master_sevenseg.sv
// Directed bench for spi_master_sevenseg: a default instance and a
// CLK_DIV=1/TAIL_CLKS=2 instance, each watched by an SPI slave monitor.
module tb_spi_master_sevenseg;

   logic       clk;
   logic       rst_n;
   logic       v0, v1;
   logic [1:0] c0, c1;
   logic [3:0] d0, d1;
   logic       rdy0, rdy1, sclk0, sclk1, ss0, ss1, mosi0, mosi1;
   logic       busy0, busy1, done0, done1;

   spi_master_sevenseg dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(v0), .in_ready_o(rdy0),
      .in_cmd_i(c0), .in_data_i(d0), .sclk_o(sclk0), .ss_o(ss0),
      .mosi_o(mosi0), .busy_o(busy0), .done_o(done0)
   );

   spi_master_sevenseg #(.CLK_DIV(1), .TAIL_CLKS(2), .GAP_CYCLES(4)) dut_t (
      .clk(clk), .rst_n(rst_n), .in_valid_i(v1), .in_ready_o(rdy1),
      .in_cmd_i(c1), .in_data_i(d1), .sclk_o(sclk1), .ss_o(ss1),
      .mosi_o(mosi1), .busy_o(busy1), .done_o(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [1:0] m_sclk = {sclk1, sclk0};
   wire [1:0] m_ss   = {ss1, ss0};
   wire [1:0] m_mosi = {mosi1, mosi0};
   wire [1:0] m_done = {done1, done0};

   logic [1:0] prev_ss   = 2'b11;
   logic [1:0] prev_sclk = 2'b00;
   logic [7:0] cur_bits [2];
   int         cur_rises [2];
   int         cur_len [2];
   int         cur_gap [2];
   int         hi_run [2];
   int         nrec [2];
   int         rise_total [2];
   int         bad_edge [2];
   int         done_total [2];
   int         done_at_rise [2];
   logic [7:0] rec_bits [2][64];
   int         rec_rises [2][64];
   int         rec_len [2][64];
   int         rec_gap [2][64];

   // Slave-side monitor: records each ss-low window as one frame
   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (!m_ss[m] && prev_ss[m]) begin
            cur_gap[m]   <= hi_run[m];
            cur_len[m]   <= 1;
            cur_bits[m]  <= 8'h00;
            cur_rises[m] <= 0;
            hi_run[m]    <= 0;
         end else if (m_ss[m] && !prev_ss[m]) begin
            if (nrec[m] < 64) begin
               rec_bits[m][nrec[m]]  <= cur_bits[m];
               rec_rises[m][nrec[m]] <= cur_rises[m];
               rec_len[m][nrec[m]]   <= cur_len[m];
               rec_gap[m][nrec[m]]   <= cur_gap[m];
            end
            nrec[m]   <= nrec[m] + 1;
            hi_run[m] <= 1;
            if (m_done[m]) done_at_rise[m] <= done_at_rise[m] + 1;
         end else if (m_ss[m]) begin
            hi_run[m] <= hi_run[m] + 1;
         end else begin
            cur_len[m] <= cur_len[m] + 1;
         end
         if (m_sclk[m] && !prev_sclk[m]) begin
            rise_total[m] <= rise_total[m] + 1;
            if (m_ss[m]) begin
               bad_edge[m] <= bad_edge[m] + 1;
            end else begin
               cur_bits[m]  <= {cur_bits[m][6:0], m_mosi[m]};
               cur_rises[m] <= cur_rises[m] + 1;
            end
         end
         if (m_done[m]) done_total[m] <= done_total[m] + 1;
      end
      prev_ss   <= m_ss;
      prev_sclk <= m_sclk;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_frames(input int m, input int n, input string tag);
      int k;
      k = 0;
      while (nrec[m] < n && k < 3000) begin
         cyc(1);
         k++;
      end
      check(tag, nrec[m], n);
   endtask

   logic [5:0] exp_q [20];
   int         base, rb, dn, dr, k, bad;
   logic       seen;
   logic [7:0] fb;

   initial begin
      rst_n = 1'b0;
      v0 = 1'b0; c0 = 2'b00; d0 = 4'h0;
      v1 = 1'b0; c1 = 2'b00; d1 = 4'h0;
      cyc(3);
      check("rst_ss", ss0, 1'b1);
      check("rst_sclk", sclk0, 1'b0);
      check("rst_mosi", mosi0, 1'b0);
      check("rst_ready", rdy0, 1'b1);
      check("rst_busy", busy0, 1'b0);
      check("rst_done", done0, 1'b0);
      check("rst_ss_tail", ss1, 1'b1);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         if (ss0 !== 1'b1 || sclk0 !== 1'b0 || mosi0 !== 1'b0 || rdy0 !== 1'b1 || busy0 !== 1'b0)
            bad++;
      end
      check("idle_100", bad, 0);
      check("idle_no_frames", nrec[0], 0);

      // Single frame {10,5}
      base = nrec[0]; dn = done_total[0]; dr = done_at_rise[0];
      v0 = 1'b1; c0 = 2'b10; d0 = 4'h5;
      cyc(1);
      v0 = 1'b0;
      check("acc_ready_low", rdy0, 1'b0);
      check("acc_busy", busy0, 1'b1);
      check("acc_ss_still_high", ss0, 1'b1);
      cyc(1);
      check("load_ss_low", ss0, 1'b0);
      check("load_mosi_msb", mosi0, 1'b1);
      check("load_ready_high", rdy0, 1'b1);
      wait_frames(0, base + 1, "single_wait");
      check("single_bits", rec_bits[0][base][5:0], 6'b100101);
      check("single_rises", rec_rises[0][base], 6);
      check("single_ss_low", rec_len[0][base], 48);
      check("single_done_cnt", done_total[0] - dn, 1);
      check("single_done_at_rise", done_at_rise[0] - dr, 1);
      fb = rec_bits[0][base];
      check("slave_digit", fb[3:0], 4'h5);
      check("slave_dp_off", (fb[5:4] == 2'b01), 1'b0);
      check("slave_on", (fb[5:4] == 2'b10) || (fb[5:4] == 2'b01), 1'b1);
      cyc(10);

      // Back-to-back {01,A},{11,3}, then {10,F} held against a full hold register
      base = nrec[0];
      v0 = 1'b1; c0 = 2'b01; d0 = 4'hA;
      cyc(1);
      c0 = 2'b11; d0 = 4'h3;
      check("b2b_ready_low", rdy0, 1'b0);
      cyc(1);
      check("b2b_ss_low", ss0, 1'b0);
      check("b2b_ready_high", rdy0, 1'b1);
      cyc(1);
      c0 = 2'b10; d0 = 4'hF;
      check("b2b_second_held", rdy0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (rdy0) seen = 1'b1;
      end
      check("bp_ready_stays_low", seen, 1'b0);
      k = 0;
      while (!rdy0 && k < 500) begin
         cyc(1);
         k++;
      end
      check("bp_ready_rises", rdy0, 1'b1);
      cyc(1);
      v0 = 1'b0;
      wait_frames(0, base + 3, "b2b_wait");
      check("b2b_bits_a", rec_bits[0][base][5:0], 6'b011010);
      check("b2b_bits_b", rec_bits[0][base + 1][5:0], 6'b110011);
      check("bp_bits_f", rec_bits[0][base + 2][5:0], 6'b101111);
      check("b2b_len_b", rec_len[0][base + 1], 48);
      check("b2b_gap_b", rec_gap[0][base + 1] >= 4, 1'b1);
      check("b2b_gap_f", rec_gap[0][base + 2] >= 4, 1'b1);
      cyc(10);

      // Twenty random frames through the handshake, scoreboarded
      base = nrec[0];
      for (int i = 0; i < 20; i++) begin
         c0 = 2'($urandom_range(3, 0));
         d0 = 4'($urandom_range(15, 0));
         v0 = 1'b1;
         k = 0;
         while (!rdy0 && k < 300) begin
            cyc(1);
            k++;
         end
         cyc(1);
         exp_q[i] = {c0, d0};
      end
      v0 = 1'b0;
      wait_frames(0, base + 20, "rand_wait");
      cyc(300);
      check("rand_no_dup", nrec[0], base + 20);
      for (int i = 0; i < 20; i++)
         check($sformatf("rand_frame_%0d", i), rec_bits[0][base + i][5:0], exp_q[i]);

      // Reset after the third rising edge of {10,8} with {11,2} queued
      cyc(10);
      base = nrec[0]; rb = rise_total[0];
      v0 = 1'b1; c0 = 2'b10; d0 = 4'h8;
      cyc(1);
      c0 = 2'b11; d0 = 4'h2;
      cyc(2);
      v0 = 1'b0;
      check("mid_queued", rdy0, 1'b0);
      k = 0;
      while (rise_total[0] < rb + 3 && k < 200) begin
         cyc(1);
         k++;
      end
      check("mid_third_edge", rise_total[0], rb + 3);
      rst_n = 1'b0;
      #1;
      check("mid_ss", ss0, 1'b1);
      check("mid_sclk", sclk0, 1'b0);
      check("mid_busy", busy0, 1'b0);
      check("mid_ready", rdy0, 1'b1);
      check("mid_mosi", mosi0, 1'b0);
      cyc(3);
      rst_n = 1'b1;
      rb = rise_total[0];
      cyc(200);
      check("mid_no_edges", rise_total[0], rb);
      check("mid_no_queued_frame", nrec[0], base + 1);
      check("mid_partial_rises", rec_rises[0][base], 3);
      check("no_edge_ss_high", bad_edge[0], 0);

      // Tail clocks instance: {10,5} then {01,F}
      base = nrec[1]; dn = done_total[1]; dr = done_at_rise[1];
      v1 = 1'b1; c1 = 2'b10; d1 = 4'h5;
      cyc(1);
      c1 = 2'b01; d1 = 4'hF;
      cyc(2);
      v1 = 1'b0;
      wait_frames(1, base + 2, "tail_wait");
      check("tail_rises_0", rec_rises[1][base], 8);
      check("tail_bits_0", rec_bits[1][base], 8'b10010100);
      check("tail_len_0", rec_len[1][base], 16);
      check("tail_rises_1", rec_rises[1][base + 1], 8);
      check("tail_bits_1", rec_bits[1][base + 1], 8'b01111100);
      check("tail_gap_1", rec_gap[1][base + 1] >= 4, 1'b1);
      check("tail_done_cnt", done_total[1] - dn, 2);
      check("tail_done_at_rise", done_at_rise[1] - dr, 2);
      check("tail_no_edge_ss_high", bad_edge[1], 0);
      cyc(10);
      check("tail_idle_busy", busy1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
